pipelined_segmented_adder: RTL and testbench

//  Parametrised, pipelined unsigned adder/subtractor: Sum = A +/- zero_extend(B), width A_WIDTH+1.

---
 rtl/pipelined_segmented_adder_pkg.sv | 14 +
 rtl/pipelined_segmented_adder_chk.sv | 31 +++
 rtl/pipelined_segmented_adder_segment.sv | 18 +
 rtl/pipelined_segmented_adder.sv | 125 ++++++++++++
 tb/tb_pipelined_segmented_adder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_segmented_adder_pkg.sv
// Shared defaults and elaboration helpers for the segmented adder.
// The segment count is derived here so every user sizes the pipe the same way.
package adder_pkg;

    localparam int DEFAULT_A_WIDTH   = 32'sd57;
    localparam int DEFAULT_B_WIDTH   = 32'sd36;
    localparam int DEFAULT_SEG_WIDTH = 32'sd16;

    // Number of slices needed to cover num bits with den-bit slices.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 32'sd1) / den;
    endfunction

endpackage

// File: rtl/pipelined_segmented_adder_chk.sv
// Interface properties of the segmented adder: stall stability, ready rule, reset flush.
module pipelined_segmented_adder_chk #(
    parameter int SUM_WIDTH = 58
) (
    input logic                 clk,
    input logic                 reset_n,
    input logic                 in_ready,
    input logic                 out_valid,
    input logic                 out_ready,
    input logic [SUM_WIDTH-1:0] Sum
);

    property p_stall_hold;
        @(posedge clk) disable iff (!reset_n)
            (out_valid && !out_ready) |=> (out_valid && $stable(Sum));
    endproperty

    property p_ready_rule;
        @(posedge clk) disable iff (!reset_n)
            in_ready == (!out_valid || out_ready);
    endproperty

    property p_reset_flush;
        @(posedge clk) !reset_n |=> !out_valid;
    endproperty

    a_stall_hold:  assert property (p_stall_hold);
    a_ready_rule:  assert property (p_ready_rule);
    a_reset_flush: assert property (p_reset_flush);

endmodule

// File: rtl/pipelined_segmented_adder_segment.sv
// One combinational slice of the segmented adder: W-bit sum with carry in/out.
module adder_segment #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
    assign o_sum   = w_total[W-1:0];
    assign o_cout  = w_total[W];

endmodule

// File: rtl/pipelined_segmented_adder.sv
// Pipelined unsigned adder/subtractor: one SEG_WIDTH slice of carry per cycle,
// operands skewed forward through the pipe, whole pipe advances together.
module pipelined_segmented_adder
    import adder_pkg::*;
#(
    parameter int A_WIDTH   = DEFAULT_A_WIDTH,
    parameter int B_WIDTH   = DEFAULT_B_WIDTH,
    parameter int SEG_WIDTH = DEFAULT_SEG_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sub,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH:0]   Sum
);

    localparam int NUM_SEG = ceil_div(A_WIDTH, SEG_WIDTH);
    localparam int LAST_W  = A_WIDTH - (NUM_SEG - 1) * SEG_WIDTH;

    if (B_WIDTH > A_WIDTH) begin : g_bad_b_width
        $fatal(1, "pipelined_segmented_adder: B_WIDTH must not exceed A_WIDTH");
    end
    if (SEG_WIDTH < 1 || SEG_WIDTH > A_WIDTH) begin : g_bad_seg_width
        $fatal(1, "pipelined_segmented_adder: SEG_WIDTH must be in 1..A_WIDTH");
    end

    // Stage 0 is the capture register; stage k+1 holds the result after slice k.
    logic               r_v     [0:NUM_SEG];
    logic               r_cy    [0:NUM_SEG];
    logic [A_WIDTH-1:0] r_a     [0:NUM_SEG-1];
    logic [A_WIDTH-1:0] r_b     [0:NUM_SEG-1];
    logic [A_WIDTH-1:0] r_res   [1:NUM_SEG];

    logic [A_WIDTH-1:0] w_res_nxt [0:NUM_SEG-1];
    logic               w_cy_nxt  [0:NUM_SEG-1];
    logic [A_WIDTH-1:0] w_b_ext;
    logic [A_WIDTH-1:0] w_b_op;
    logic               w_adv;

    assign w_adv     = !r_v[NUM_SEG] || out_ready;
    assign in_ready  = w_adv || !reset_n;
    assign out_valid = r_v[NUM_SEG];
    assign Sum       = {r_cy[NUM_SEG], r_res[NUM_SEG]};

    // Zero-extend B and fold in the one's complement for subtraction.
    always_comb begin
        w_b_ext = A_WIDTH'(B);
        if (in_sub) begin
            w_b_op = ~w_b_ext;
        end else begin
            w_b_op = w_b_ext;
        end
    end

    for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
        localparam int LO = k * SEG_WIDTH;
        localparam int W  = (k == NUM_SEG - 1) ? LAST_W : SEG_WIDTH;
        localparam logic [A_WIDTH-1:0] MASK = ({A_WIDTH{1'b1}} >> (A_WIDTH - W)) << LO;

        logic [W-1:0] w_sum;
        logic         w_cout;

        adder_segment #(.W(W)) u_seg (
            .i_a    (r_a[k][LO +: W]),
            .i_b    (r_b[k][LO +: W]),
            .i_cin  (r_cy[k]),
            .o_sum  (w_sum),
            .o_cout (w_cout)
        );

        // Earlier slices are frozen; only this slice's bits are inserted.
        if (k == 0) begin : g_first
            assign w_res_nxt[k] = A_WIDTH'(w_sum) & MASK;
        end else begin : g_rest
            assign w_res_nxt[k] = (r_res[k] & ~MASK) | ((A_WIDTH'(w_sum) << LO) & MASK);
        end
        assign w_cy_nxt[k] = w_cout;
    end

    // Pipeline registers: flush on reset, shift together on advance, hold otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k <= NUM_SEG; k++) begin
                r_v[k]  <= 1'b0;
                r_cy[k] <= 1'b0;
            end
            for (int k = 0; k < NUM_SEG; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            for (int k = 1; k <= NUM_SEG; k++) begin
                r_res[k] <= '0;
            end
        end else if (w_adv) begin
            r_v[0]  <= in_valid;
            r_cy[0] <= in_sub;
            r_a[0]  <= A;
            r_b[0]  <= w_b_op;
            for (int k = 1; k < NUM_SEG; k++) begin
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
            end
            for (int k = 0; k < NUM_SEG; k++) begin
                r_v[k+1]   <= r_v[k];
                r_cy[k+1]  <= w_cy_nxt[k];
                r_res[k+1] <= w_res_nxt[k];
            end
        end
    end

    pipelined_segmented_adder_chk #(.SUM_WIDTH(A_WIDTH + 1)) u_chk (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum)
    );

endmodule

// File: tb/tb_pipelined_segmented_adder.sv
// Self-checking bench for pipelined_segmented_adder: random and directed beats
// against an arithmetic reference model with a latency/stall-aware scoreboard.
module tb_pipelined_segmented_adder;

    localparam int AW  = 57;
    localparam int BW  = 36;
    localparam int SW  = 16;
    localparam int LAT = 4;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic          in_sub    = 1'b0;
    logic [AW-1:0] A         = '0;
    logic [BW-1:0] B         = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW:0]   Sum;

    always #5 clk = ~clk;

    pipelined_segmented_adder #(.A_WIDTH(AW), .B_WIDTH(BW), .SEG_WIDTH(SW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sub    (in_sub),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum)
    );

    typedef struct {
        logic [AW:0] sum;
        int          acc;
        int          snap;
    } exp_t;

    exp_t q[$];
    int   n_cmp     = 0;
    int   n_err     = 0;
    int   cyc       = 0;
    int   stall_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Plain arithmetic: add gives a 58-bit sum, subtract gives {A>=B, A-B mod 2^57}.
    function automatic logic [AW:0] ref_sum(input logic sub, input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic [AW:0] ea;
        logic [AW:0] eb;
        ea = {1'b0, a};
        eb = {{(AW+1-BW){1'b0}}, b};
        if (!sub) return ea + eb;
        return {(ea >= eb), a - eb[AW-1:0]};
    endfunction

    function automatic logic [AW-1:0] rand_a();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       return {AW{1'b1}};
            1:       return AW'(r[7:0]);
            default: return r[AW-1:0];
        endcase
    endfunction

    function automatic logic [BW-1:0] rand_b();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       return {BW{1'b1}};
            1:       return BW'(r[7:0]);
            default: return r[BW-1:0];
        endcase
    endfunction

    // One clock: drive at negedge, check outputs, update scoreboard, cross posedge.
    task automatic step(input logic v, input logic sub, input logic [AW-1:0] a, input logic [BW-1:0] b,
                        input logic ordy, input logic use_fix, input logic [AW:0] fix, output logic took);
        logic exp_v;
        exp_t e;
        in_valid  = v;
        in_sub    = sub;
        A         = a;
        B         = b;
        out_ready = ordy;
        took      = 1'b0;
        #1;
        if (!reset_n) begin
            check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        end else begin
            exp_v = (q.size() > 0) && (cyc >= q[0].acc + LAT + (stall_cnt - q[0].snap));
            check_eq("out_valid", 64'(out_valid), 64'(exp_v));
            check_eq("in_ready", 64'(in_ready), 64'(!exp_v || ordy));
            if (exp_v) begin
                check_eq("sum", 64'(Sum), 64'(q[0].sum));
                if (ordy) void'(q.pop_front());
                else stall_cnt++;
            end
            if (v && (!exp_v || ordy)) begin
                e.sum  = use_fix ? fix : ref_sum(sub, a, b);
                e.acc  = cyc + 1;
                e.snap = stall_cnt;
                q.push_back(e);
                took = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        if (!reset_n) q.delete();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic t;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, t);
    endtask

    task automatic directed(input logic sub, input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [AW:0] fix);
        logic t;
        step(1'b1, sub, a, b, 1'b1, 1'b1, fix, t);
        check_eq("dir_accept", 64'(t), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 60) begin
            idle(1);
            n++;
        end
        check_eq("drain_empty", 64'(q.size()), 64'd0);
        idle(6);
    endtask

    // Random beats; a beat offered but not taken stays on the bus unchanged.
    task automatic run_stream(input int nbeats, input int stall_lo, input int stall_hi,
                              input int p_gap, input int p_stall);
        int            sent = 0;
        int            i    = 0;
        logic          took;
        logic          v;
        logic          hold = 1'b0;
        logic          ordy;
        logic          sub  = 1'b0;
        logic [AW-1:0] a    = '0;
        logic [BW-1:0] b    = '0;
        while (sent < nbeats && i < 2000) begin
            if (!hold) begin
                a   = rand_a();
                b   = rand_b();
                sub = 1'($urandom_range(0, 1));
                v   = ($urandom_range(0, 99) >= p_gap);
            end else begin
                v = 1'b1;
            end
            ordy = !(i >= stall_lo && i <= stall_hi) && ($urandom_range(0, 99) >= p_stall);
            step(v, sub, a, b, ordy, 1'b0, '0, took);
            hold = v && !took;
            if (took) sent++;
            i++;
        end
        check_eq("stream_sent", 64'(sent), 64'(nbeats));
    endtask

    initial begin
        logic          t;
        logic [AW:0]   two57;
        logic [AW-1:0] ones_a;
        logic [BW-1:0] ones_b;
        two57  = {1'b1, {AW{1'b0}}};
        ones_a = {AW{1'b1}};
        ones_b = {BW{1'b1}};

        @(negedge clk);
        // Reset held with in_valid high: nothing may be captured.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_a(), rand_b(), 1'b1, 1'b0, '0, t);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_sum", 64'(Sum), 64'd0);
        reset_n = 1'b1;
        idle(5);

        // Full carry ripple across every slice.
        directed(1'b0, ones_a, 36'd1, two57);
        drain();

        // Subtract boundaries.
        directed(1'b1, 57'd7, 36'd5, two57 | 58'd2);
        directed(1'b1, 57'd5, 36'd7, {1'b0, ones_a - 57'd1});
        directed(1'b1, {21'd0, ones_b}, ones_b, two57);
        directed(1'b0, 57'd0, 36'd0, 58'd0);
        drain();

        // Back-to-back streaming, then a mid-stream stall.
        run_stream(8, -1, -2, 0, 0);
        drain();
        run_stream(8, 5, 7, 0, 0);
        drain();

        // Reset with beats in flight: none of them may emerge.
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)), rand_a(), rand_b(), 1'b1, 1'b0, '0, t);
        reset_n = 1'b0;
        idle(1);
        check_eq("rst_mid_valid", 64'(out_valid), 64'd0);
        check_eq("rst_mid_sum", 64'(Sum), 64'd0);
        reset_n = 1'b1;
        idle(8);

        // Random traffic with gaps and backpressure.
        run_stream(300, -1, -2, 25, 30);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
